// File: rtl/ntt_coeff_unloader.sv
// ntt_coeff_unloader
//   Drains a finished polynomial from the dual-read coefficient register file
//   and streams it out one coefficient per beat. Each fetch reads an
//   even/odd pair through the file's two combinational read ports, so the
//   stream runs at one coefficient per cycle with no bubbles.
//   Optional bit-reversed address mapping undoes bit-reversed storage order.
//   A sticky flag reports any emitted coefficient that is not reduced mod Q.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle unload request, honoured only when idle
//   busy, done           unload in progress / one-cycle pulse on final beat
//   range_err            sticky: some coefficient was >= Q; cleared by start
//   rd_addr_a/b          read addresses for even/odd output index
//   rd_data_a/b          combinational read data
//   m_data/m_valid/m_ready/m_last   output stream
module ntt_coeff_unloader #(
    parameter int N      = 256,
    parameter int AW     = 8,
    parameter int DW     = 12,
    parameter int Q      = 3329,
    parameter int BITREV = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          range_err,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [DW-1:0] rd_data_a,
    input  logic [DW-1:0] rd_data_b,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [AW-1:0] P_LAST = AW'(N / 2);

    state_t          state_q, state_d;
    logic [AW-1:0]   p_q, p_d;        // index of the next pair to fetch
    logic            half_q, half_d;  // 0: lo beat on the bus, 1: hi beat
    logic [DW-1:0]   lo_q, lo_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            rerr_q, rerr_d;

    logic            xfer;
    logic            cap_err;
    logic [AW-1:0]   idx_a, idx_b;

    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        r = x;
        if (BITREV != 0) begin
            for (int k = 0; k < AW; k++) r[k] = x[AW-1-k];
        end
        return r;
    endfunction

    // Pair p holds output indices 2p and 2p+1. Once the last pair is loaded
    // p sits at N/2 and the addresses wrap; the read data is then unused.
    assign idx_a     = {p_q[AW-2:0], 1'b0};
    assign idx_b     = {p_q[AW-2:0], 1'b1};
    assign rd_addr_a = map_addr(idx_a);
    assign rd_addr_b = map_addr(idx_b);

    // Out-of-range check on the pair currently presented by the read ports;
    // it only matters on the cycles that pair is captured.
    assign cap_err = ({{(32-DW){1'b0}}, rd_data_a} >= 32'(Q)) ||
                     ({{(32-DW){1'b0}}, rd_data_b} >= 32'(Q));

    assign xfer      = valid_q && m_ready;
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign range_err = rerr_q;
    assign m_valid   = valid_q;
    assign m_data    = half_q ? hi_q : lo_q;
    assign m_last    = valid_q && half_q && (p_q == P_LAST);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        half_d  = half_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    lo_d    = rd_data_a;
                    hi_d    = rd_data_b;
                    p_d     = AW'(1);
                    half_d  = 1'b0;
                    valid_d = 1'b1;
                    rerr_d  = cap_err;  // fresh unload: old flag discarded
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (p_q != P_LAST) begin
                        // Refill on the hi beat so the next lo is ready at once.
                        lo_d   = rd_data_a;
                        hi_d   = rd_data_b;
                        p_d    = p_q + 1'b1;
                        half_d = 1'b0;
                        rerr_d = rerr_q | cap_err;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        p_d     = '0;
                        half_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            half_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            half_q  <= half_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rerr_q  <= rerr_d;
        end
    end

endmodule

// File: doc/ntt_coeff_unloader.md
Name: ntt_coeff_unloader

Overview:
Drains a completed polynomial from the dual-read coefficient register file and serializes it onto a valid/ready stream, one coefficient per beat. Reads two coefficients per fetch through the file's two asynchronous read ports (addr_a/addr_b, combinational data). It sits between the NTT/INTT core's coefficient storage and the output interface (host or DMA). It can optionally undo bit-reversed storage order and flags coefficients that are not reduced mod Q.

Parameters:
N, 256, coefficients per polynomial; even power of two.
AW, 8, address width; log2(N).
DW, 12, coefficient width.
Q, 3329, modulus used for the range check.
BITREV, 0, 1 = output index i is read from address bitrev_AW(i); 0 = identity order.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle request to begin an unload; honoured only when idle.
busy  out  1  high while an unload is in progress.
done  out  1  one-cycle pulse when the final beat is accepted.
range_err  out  1  sticky: some emitted coefficient was >= Q; cleared by an accepted start.
rd_addr_a  out  AW  register-file read address, port A (even output index).
rd_addr_b  out  AW  register-file read address, port B (odd output index).
rd_data_a  in  DW  port A read data, combinational from rd_addr_a.
rd_data_b  in  DW  port B read data, combinational from rd_addr_b.
m_data  out  DW  stream data.
m_valid  out  1  stream valid.
m_ready  in  1  stream ready.
m_last  out  1  high with the beat for output index N-1.

Behaviour:
- Reset: state IDLE; pair counter p=0; busy=0; done=0; range_err=0; m_valid=0; m_last=0; m_data=0; pair register empty; half-select=0.
- Addressing (combinational from p): rd_addr_a = map(2p), rd_addr_b = map(2p+1). map is bitrev_AW when BITREV=1, else identity. In IDLE, p=0, so the addresses present pair 0.
- State machine: IDLE and RUN.
  - IDLE + start:
    - Capture {rd_data_a, rd_data_b} into the pair register (lo, hi).
    - Set p=1, half=0, busy=1, m_valid=1 (first beat visible the cycle after start).
    - Clear range_err, then evaluate the captured pair.
  - IDLE without start: hold state.
- RUN, beat transfer: a beat transfers when m_valid && m_ready. m_data = half ? hi : lo.
  - Transfer with half=0: set half=1.
  - Transfer with half=1 and p < N/2: load the next pair from the read ports, p++, half=0. m_valid stays 1, so there is no bubble and the sustained rate is 1 coefficient/cycle.
  - Transfer with half=1 and p == N/2 (last beat): m_valid=0, busy=0, done=1 for one cycle, return to IDLE, p=0.
- Backpressure: while m_ready=0, m_data, m_valid, m_last and the address outputs are stable; nothing advances.
- m_last = m_valid && half==1 && p==N/2.
- range_err: set on the cycle any pair is captured with lo >= Q or hi >= Q. Comparison is unsigned, DW bits. The flag holds until the next accepted start.
- Coefficient flow: the data path is transparent; coefficients are not reduced or modified.
- start while busy: ignored; no restart, no effect on range_err.
- start on the same cycle as the final transfer: ignored (the block is not yet IDLE). It must be reissued after done.
- rst mid-unload: everything returns to reset values on the next edge; the partial stream is abandoned and m_valid drops immediately.
- The register file must not be written while busy. This block does not check that.

Test Plan:
1. Identity order: file[i]=i, BITREV=0, m_ready=1, start at cycle 0 -> m_valid from cycle 1; m_data 0,1,...,255 on cycles 1..256; m_last only on 255; done pulse in cycle 257; busy falls with it.
2. Bit-reversed order: file[i]=i, BITREV=1 -> stream 0,128,64,192,32,... (bitrev8 of 0..255). rd_addr_a/rd_addr_b for pair 1 are 64/192.
3. Backpressure: toggle m_ready 1,0,0,1 repeatedly, plus random ready -> every value still appears exactly once and in order. m_data is stable while m_valid && !m_ready. Exactly 256 transfers, then one done.
4. Range check: file[37]=3329, all others < 3329 -> range_err rises after pair 18 is captured and stays 1 to the end. A second start with clean data clears it to 0.
5. Start abuse: pulse start at beats 10 and 255 (while busy) -> no disturbance; still 256 beats and a single done.
6. Reset mid-unload: assert rst at beat 100 -> next cycle m_valid=0, busy=0, range_err=0. A following start restarts from index 0.
